// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: samples a multiplexed 7-segment scan bus, qualifies each
// digit pattern for stability, decodes it to BCD and publishes complete frames
// through a valid/ack handshake.
module seg7_scan_decoder #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                seg_in,
    input  logic [NUM_DIGITS-1:0]     dig_en,
    output logic [4*NUM_DIGITS-1:0]   bcd_out,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic                      frame_valid,
    input  logic                      frame_ack,
    output logic                      err_pulse,
    output logic                      overrun
);

    // Counter value reached after STABLE_CYCLES consecutive samples of one pattern.
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    // {legal, value}; illegal patterns decode to 4'hF.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1111110: r = {1'b1, 4'd0};
            7'b0110000: r = {1'b1, 4'd1};
            7'b1101101: r = {1'b1, 4'd2};
            7'b1111001: r = {1'b1, 4'd3};
            7'b0110011: r = {1'b1, 4'd4};
            7'b1011011: r = {1'b1, 4'd5};
            7'b1011111: r = {1'b1, 4'd6};
            7'b1110000: r = {1'b1, 4'd7};
            7'b1111111: r = {1'b1, 4'd8};
            7'b1111011: r = {1'b1, 4'd9};
            default:    r = {1'b0, 4'hF};
        endcase
        return r;
    endfunction

    logic [6:0]              seg_q, seg_prev_q;
    logic [NUM_DIGITS-1:0]   dig_q, dig_prev_q;
    logic [7:0]              cnt_q, cnt_d;
    logic                    committed_q, committed_d;
    logic [4*NUM_DIGITS-1:0] work_q, work_d;
    logic [NUM_DIGITS-1:0]   wvalid_q, wvalid_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   dv_q, dv_d;
    logic                    fv_q, fv_d;
    logic                    err_q, err_d;
    logic                    ov_q, ov_d;

    logic                    same;
    logic                    commit;
    logic                    complete;
    logic                    multi_hot;
    logic [4:0]              dec;

    // Input stage plus one-sample history used by the stability qualifier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q      <= '0;
            dig_q      <= '0;
            seg_prev_q <= '0;
            dig_prev_q <= '0;
        end else begin
            seg_q      <= seg_in;
            dig_q      <= dig_en;
            seg_prev_q <= seg_q;
            dig_prev_q <= dig_q;
        end
    end

    // Stability qualifier: the committed pattern is the older sample, since the
    // count reflects how long that sample matched its predecessor.
    always_comb begin
        same        = (seg_q == seg_prev_q) && (dig_q == dig_prev_q);
        commit      = (cnt_q == CNT_MAX) && !committed_q;
        cnt_d       = '0;
        committed_d = 1'b0;
        if (same) begin
            cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
            committed_d = committed_q | commit;
        end
    end

    // Digit commit into the working bank and frame completion / handshake.
    always_comb begin
        multi_hot = (dig_prev_q & (dig_prev_q - 1'b1)) != '0;
        dec       = decode(seg_prev_q);
        complete  = &seen_q;
        work_d    = work_q;
        wvalid_d  = wvalid_q;
        seen_d    = complete ? '0 : seen_q;
        err_d     = 1'b0;
        if (commit && (dig_prev_q != '0)) begin
            if (multi_hot) begin
                err_d = 1'b1;
            end else begin
                for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                    if (dig_prev_q[k]) begin
                        work_d[4*k +: 4] = dec[3:0];
                        wvalid_d[k]      = dec[4];
                        seen_d[k]        = 1'b1;
                    end
                end
                err_d = !dec[4];
            end
        end
        bcd_d = complete ? work_q : bcd_q;
        dv_d  = complete ? wvalid_q : dv_q;
        if (complete) begin
            fv_d = 1'b1;
        end else if (frame_ack && fv_q) begin
            fv_d = 1'b0;
        end else begin
            fv_d = fv_q;
        end
        ov_d = complete && fv_q && !frame_ack;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            committed_q <= 1'b0;
            work_q      <= '0;
            wvalid_q    <= '0;
            seen_q      <= '0;
            bcd_q       <= '0;
            dv_q        <= '0;
            fv_q        <= 1'b0;
            err_q       <= 1'b0;
            ov_q        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            committed_q <= committed_d;
            work_q      <= work_d;
            wvalid_q    <= wvalid_d;
            seen_q      <= seen_d;
            bcd_q       <= bcd_d;
            dv_q        <= dv_d;
            fv_q        <= fv_d;
            err_q       <= err_d;
            ov_q        <= ov_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign digit_valid = dv_q;
    assign frame_valid = fv_q;
    assign err_pulse   = err_q;
    assign overrun     = ov_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scan sequences, a run-length based
// reference model compared every cycle, plus literal expectations per scenario.
module tb_seg7_scan_decoder;

    localparam int S = 4;
    localparam logic [6:0] SEGS [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                         7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_in = '0;
    logic [3:0]  dig_en = '0;
    logic        frame_ack = 1'b0;
    logic [15:0] bcd_out;
    logic [3:0]  digit_valid;
    logic        frame_valid, err_pulse, overrun;

    int n_checks = 0;
    int n_errors = 0;
    int err_seen = 0;
    int ov_seen  = 0;

    seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_en(dig_en),
        .bcd_out(bcd_out), .digit_valid(digit_valid), .frame_valid(frame_valid),
        .frame_ack(frame_ack), .err_pulse(err_pulse), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [10:0] h [0:S+1];
    logic [3:0]  w [4];
    logic [3:0]  m_wv = '0, m_seen = '0, m_dv = '0;
    logic [15:0] m_bcd = '0;
    logic        m_fv = 0, m_err = 0, m_ov = 0;

    function automatic logic [4:0] mdec(input logic [6:0] s);
        logic [4:0] r = {1'b0, 4'hF};
        for (int v = 0; v < 10; v++) if (SEGS[v] == s) r = {1'b1, 4'(v)};
        return r;
    endfunction

    // A pattern is committed S+1 edges after a run of at least S identical samples began.
    initial begin
        for (int i = 0; i <= S + 1; i++) h[i] = '0;
        for (int i = 0; i < 4; i++) w[i] = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i <= S + 1; i++) h[i] = '0;
                for (int i = 0; i < 4; i++) w[i] = '0;
                m_wv = '0; m_seen = '0; m_dv = '0; m_bcd = '0;
                m_fv = 0; m_err = 0; m_ov = 0;
            end else begin
                logic run_ok, done;
                logic [3:0] dg;
                logic [4:0] d;
                run_ok = 1'b1;
                for (int i = 2; i <= S; i++) if (h[i] != h[1]) run_ok = 1'b0;
                if (h[S+1] == h[1]) run_ok = 1'b0;
                done  = (m_seen == 4'hF);
                m_ov  = done && m_fv && !frame_ack;
                m_err = 1'b0;
                if (done) begin
                    m_bcd = {w[3], w[2], w[1], w[0]};
                    m_dv = m_wv; m_fv = 1'b1; m_seen = '0;
                end else if (frame_ack) begin
                    m_fv = 1'b0;
                end
                if (run_ok) begin
                    dg = h[1][3:0];
                    if ($countones(dg) > 1) m_err = 1'b1;
                    else if ($countones(dg) == 1) begin
                        d = mdec(h[1][10:4]);
                        for (int k = 0; k < 4; k++) if (dg[k]) begin
                            w[k] = d[3:0]; m_wv[k] = d[4]; m_seen[k] = 1'b1;
                        end
                        m_err = !d[4];
                    end
                end
                for (int i = S + 1; i > 0; i--) h[i] = h[i-1];
                h[0] = {seg_in, dig_en};
            end
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        err_seen += int'(err_pulse);
        ov_seen  += int'(overrun);
        check("cyc bcd_out", 32'(bcd_out), 32'(m_bcd));
        check("cyc digit_valid", 32'(digit_valid), 32'(m_dv));
        check("cyc frame_valid", 32'(frame_valid), 32'(m_fv));
        check("cyc err_pulse", 32'(err_pulse), 32'(m_err));
        check("cyc overrun", 32'(overrun), 32'(m_ov));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [6:0] s, input logic [3:0] d, input int n);
        seg_in = s; dig_en = d;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input int k, input logic [6:0] s);
        drive(s, 4'(1 << k), 8);
        drive(7'h00, 4'h0, 2);
    endtask

    task automatic ack;
        frame_ack = 1'b1;
        @(posedge clk); #1;
        frame_ack = 1'b0;
    endtask

    task automatic pin(input string name, input logic [31:0] dut_v,
                       input logic [31:0] mod_v, input logic [31:0] exp);
        check({name, " dut"}, dut_v, exp);
        check({name, " model"}, mod_v, exp);
    endtask

    initial begin
        int e0, o0;
        @(posedge clk); #1;
        check("reset frame_valid", 32'(frame_valid), 0);
        check("reset bcd_out", 32'(bcd_out), 0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        drive(7'h00, 4'h0, 3);

        // clean frame 1,9,8,0
        e0 = err_seen;
        scan(0, SEGS[1]); scan(1, SEGS[9]); scan(2, SEGS[8]); scan(3, SEGS[0]);
        pin("T2 bcd", 32'(bcd_out), 32'(m_bcd), 32'h0891);
        pin("T2 dv", 32'(digit_valid), 32'(m_dv), 32'hF);
        pin("T2 fv", 32'(frame_valid), 32'(m_fv), 1);
        check("T2 no err", 32'(err_seen - e0), 0);
        ack();
        check("T2 fv cleared", 32'(frame_valid), 0);
        ack();
        check("T2 stray ack", 32'(frame_valid), 0);

        // glitch filter on digit 2
        e0 = err_seen;
        scan(0, SEGS[2]); scan(1, SEGS[3]);
        drive(SEGS[7], 4'b0100, 3);
        drive(SEGS[4], 4'b0100, 6);
        drive(7'h00, 4'h0, 2);
        scan(3, SEGS[5]);
        pin("T3 bcd", 32'(bcd_out), 32'(m_bcd), 32'h5432);
        check("T3 no err", 32'(err_seen - e0), 0);
        ack();

        // illegal pattern on digit 1
        e0 = err_seen;
        scan(0, SEGS[6]); scan(1, 7'b0000001); scan(2, SEGS[7]); scan(3, SEGS[8]);
        check("T4 err once", 32'(err_seen - e0), 1);
        pin("T4 bcd", 32'(bcd_out), 32'(m_bcd), 32'h87F6);
        pin("T4 dv", 32'(digit_valid), 32'(m_dv), 32'hD);

        // second frame without ack -> overrun
        o0 = ov_seen;
        scan(0, SEGS[9]); scan(1, SEGS[9]); scan(2, SEGS[9]); scan(3, SEGS[9]);
        check("T5 overrun once", 32'(ov_seen - o0), 1);
        pin("T5 bcd", 32'(bcd_out), 32'(m_bcd), 32'h9999);

        // ack coincident with third completion
        o0 = ov_seen;
        scan(0, SEGS[1]); scan(1, SEGS[2]); scan(2, SEGS[3]);
        drive(SEGS[4], 4'b1000, 6);
        ack();
        drive(SEGS[4], 4'b1000, 1);
        drive(7'h00, 4'h0, 2);
        check("T5 ack+complete fv", 32'(frame_valid), 1);
        check("T5 no overrun", 32'(ov_seen - o0), 0);
        pin("T5 bcd2", 32'(bcd_out), 32'(m_bcd), 32'h4321);
        ack();
        check("T5 fv cleared", 32'(frame_valid), 0);

        // bad enables
        e0 = err_seen;
        drive(SEGS[1], 4'b0110, 10);
        drive(7'h00, 4'h0, 2);
        check("T6 err once", 32'(err_seen - e0), 1);
        scan(0, SEGS[1]); scan(1, SEGS[2]); scan(2, SEGS[3]);
        check("T6 no early frame", 32'(frame_valid), 0);
        scan(3, SEGS[6]);
        pin("T6 bcd", 32'(bcd_out), 32'(m_bcd), 32'h6321);

        // reset mid-frame
        scan(0, SEGS[7]); scan(1, SEGS[7]);
        check("T1 fv before reset", 32'(frame_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("T1 async fv", 32'(frame_valid), 0);
        check("T1 async bcd", 32'(bcd_out), 0);
        check("T1 async dv", 32'(digit_valid), 0);
        check("T1 async err/ov", 32'({err_pulse, overrun}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        scan(2, SEGS[5]); scan(3, SEGS[8]);
        check("T1 partial dropped", 32'(frame_valid), 0);
        scan(0, SEGS[7]); scan(1, SEGS[7]);
        pin("T1 bcd", 32'(bcd_out), 32'(m_bcd), 32'h8577);
        pin("T1 fv", 32'(frame_valid), 32'(m_fv), 1);

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
